// File: rtl/car_traffic.sv
// car_traffic: six lane car X positions driven by a shared, level-scaled movement tick.
// Optional macro CAR_LFSR_EN: wrapping cars re-enter at a pseudo-random offset from a 16-bit LFSR.
module car_traffic #(
    parameter int H_DISPLAY    = 640,
    parameter int CAR_WIDTH    = 64,
    parameter int INIT_SPACING = 96,
    parameter int BASE_PERIOD  = 250000,
    parameter int LEVEL_STEP   = 25000,
    parameter int MIN_PERIOD   = 50000,
    parameter int MAX_LEVEL    = 7
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       LEVEL_UP,
    input  logic       PAUSE,
    output logic [9:0] CAR_X1,
    output logic [9:0] CAR_X2,
    output logic [9:0] CAR_X3,
    output logic [9:0] CAR_X4,
    output logic [9:0] CAR_X5,
    output logic [9:0] CAR_X6,
    output logic [2:0] LEVEL
);
    localparam logic [10:0] WRAP_LIMIT = 11'(H_DISPLAY + CAR_WIDTH);

    logic [2:0]  level_q, level_d;
    logic [31:0] cnt_q, cnt_d, period, level_off;
    logic        tick;
    logic [9:0]  car_x [6];

    // Clamp is decided before subtracting so high levels never underflow the period.
    always_comb begin
        level_off = 32'(level_q) * 32'(LEVEL_STEP);
        period    = (level_off >= 32'(BASE_PERIOD - MIN_PERIOD)) ? 32'(MIN_PERIOD) : 32'(BASE_PERIOD) - level_off;
        tick      = !PAUSE && (cnt_q == period - 32'd1);
        cnt_d     = (LEVEL_UP || tick) ? '0 : PAUSE ? cnt_q : cnt_q + 32'd1;
        level_d   = (LEVEL_UP && level_q != 3'(MAX_LEVEL)) ? level_q + 3'd1 : level_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            level_q <= '0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CAR_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`endif

    // Even indices are the odd-numbered, right-moving lanes; step grows every lane pair.
    for (genvar g = 0; g < 6; g++) begin : g_lane
        localparam logic [10:0] STEP  = 11'(g / 2 + 1);
        localparam bit          RIGHT = (g % 2) == 0;
        localparam logic [9:0]  INIT  = 10'(g * INIT_SPACING);
        logic [9:0]  x_q, x_d, wrap_x;
        logic [10:0] sum;
        logic        wrap;
        always_comb begin
            sum    = RIGHT ? {1'b0, x_q} + STEP : {1'b0, x_q} - STEP;
            wrap   = RIGHT ? (sum >= WRAP_LIMIT) : ({1'b0, x_q} < STEP);
`ifdef CAR_LFSR_EN
            wrap_x = RIGHT ? {4'b0, lfsr_q[5:0]} : 10'(WRAP_LIMIT - 11'd1 - {5'b0, lfsr_q[5:0]});
`else
            wrap_x = RIGHT ? 10'(sum - WRAP_LIMIT) : 10'(sum + WRAP_LIMIT);
`endif
            x_d    = !tick ? x_q : wrap ? wrap_x : sum[9:0];
        end
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) x_q <= INIT;
            else        x_q <= x_d;
        end
        assign car_x[g] = x_q;
    end

    assign CAR_X1 = car_x[0];
    assign CAR_X2 = car_x[1];
    assign CAR_X3 = car_x[2];
    assign CAR_X4 = car_x[3];
    assign CAR_X5 = car_x[4];
    assign CAR_X6 = car_x[5];
    assign LEVEL  = level_q;
endmodule

// File: tb/tb_car_traffic.sv
// tb_car_traffic: scoreboard bench for car_traffic with a modulo-arithmetic lane model.
// Define CAR_LFSR_EN for both files to exercise the randomised wrap variant.
module tb_car_traffic;
    localparam int BP = 10, LS = 2, MP = 4, W = 704;

    logic       CLK = 1'b0, RST_N = 1'b0, LEVEL_UP = 1'b0, PAUSE = 1'b0;
    logic [9:0] CAR_X1, CAR_X2, CAR_X3, CAR_X4, CAR_X5, CAR_X6;
    logic [2:0] LEVEL;

    car_traffic #(.BASE_PERIOD(BP), .LEVEL_STEP(LS), .MIN_PERIOD(MP)) dut (
        .CLK(CLK), .RST_N(RST_N), .LEVEL_UP(LEVEL_UP), .PAUSE(PAUSE),
        .CAR_X1(CAR_X1), .CAR_X2(CAR_X2), .CAR_X3(CAR_X3),
        .CAR_X4(CAR_X4), .CAR_X5(CAR_X5), .CAR_X6(CAR_X6), .LEVEL(LEVEL)
    );

    always #5 CLK = ~CLK;

    int passed = 0, total = 0;
    int m_x [6];
    int m_level, m_cnt, m_lfsr;
    logic [62:0] exp_q [$];

    function automatic logic [62:0] vec(int l, int a, int b, int c, int d, int e, int f);
        return {3'(l), 10'(f), 10'(e), 10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    function automatic logic [62:0] model_vec();
        return vec(m_level, m_x[0], m_x[1], m_x[2], m_x[3], m_x[4], m_x[5]);
    endfunction

    function automatic logic [62:0] dut_vec();
        return {LEVEL, CAR_X6, CAR_X5, CAR_X4, CAR_X3, CAR_X2, CAR_X1};
    endfunction

    function automatic string show(logic [62:0] v);
        return $sformatf("L=%0d X=%0d/%0d/%0d/%0d/%0d/%0d", v[62:60], v[9:0], v[19:10],
                         v[29:20], v[39:30], v[49:40], v[59:50]);
    endfunction

    task automatic check(string name, logic [62:0] act, logic [62:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %s expected %s", name, show(act), show(exp));
    endtask

    task automatic check_int(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int period_of(int l);
        return (l * LS >= BP - MP) ? MP : BP - l * LS;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_x[i] = i * 96;
        m_level = 0;
        m_cnt   = 0;
        m_lfsr  = 16'hACE1;
    endtask

    // One clock of stimulus; the model predicts the outputs visible after the coming edge.
    task automatic step(input bit lu, input bit pz);
        int p, nx;
        bit moved;
        @(negedge CLK);
        RST_N = 1'b1; LEVEL_UP = lu; PAUSE = pz;
        p = period_of(m_level);
        moved = 1'b0;
        if (!pz) begin
            m_cnt++;
            if (m_cnt >= p) begin moved = 1'b1; m_cnt = 0; end
        end
        if (lu) begin
            m_cnt = 0;
            if (m_level < 7) m_level++;
        end
        if (moved)
            for (int i = 0; i < 6; i++) begin
                nx = (i % 2 == 0) ? m_x[i] + (i / 2 + 1) : m_x[i] - (i / 2 + 1);
`ifdef CAR_LFSR_EN
                if (nx < 0 || nx >= W) nx = (i % 2 == 0) ? m_lfsr % 64 : W - 1 - m_lfsr % 64;
`endif
                m_x[i] = (nx + W) % W;
            end
        m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 16'hFFFF;
        exp_q.push_back(model_vec());
    endtask

    task automatic settle();
        @(posedge CLK);
        #2;
    endtask

    task automatic async_reset(string name);
        @(posedge CLK);
        #3;
        LEVEL_UP = 1'b0; PAUSE = 1'b0; RST_N = 1'b0;
        #1;
        model_reset();
        check(name, dut_vec(), vec(0, 0, 96, 192, 288, 384, 480));
    endtask

    task automatic step_until_move(int lane);
        int prev, n;
        prev = m_x[lane];
        n = 0;
        while (m_x[lane] == prev && n < 20) begin step(0, 0); n++; end
    endtask

    always @(posedge CLK) begin
        logic [62:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", dut_vec(), e);
            check_int("range", int'(CAR_X1 < 704 && CAR_X2 < 704 && CAR_X3 < 704 &&
                                    CAR_X4 < 704 && CAR_X5 < 704 && CAR_X6 < 704), 1);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

    initial begin
        int n;
        model_reset();
        #12;
        check("reset values", dut_vec(), vec(0, 0, 96, 192, 288, 384, 480));

        repeat (9) step(0, 0);
        settle();
        check("hold before first tick", dut_vec(), vec(0, 0, 96, 192, 288, 384, 480));
        step(0, 0);
        settle();
        check("first move", dut_vec(), vec(0, 1, 95, 194, 286, 387, 477));

        repeat (5) step(0, 0);
        repeat (50) step(0, 1);
        settle();
        check("pause frozen", dut_vec(), vec(0, 1, 95, 194, 286, 387, 477));
        repeat (4) step(0, 0);
        settle();
        check("hold after release", dut_vec(), vec(0, 1, 95, 194, 286, 387, 477));
        step(0, 0);
        settle();
        check("resume move", dut_vec(), vec(0, 2, 94, 196, 284, 390, 474));

        repeat (3) step(0, 0);
        step(1, 0);
        repeat (7) step(0, 0);
        settle();
        check("level1 hold", dut_vec(), vec(1, 2, 94, 196, 284, 390, 474));
        step(0, 0);
        settle();
        check("level1 period 8", dut_vec(), vec(1, 3, 93, 198, 282, 393, 471));
        repeat (9) step(1, 0);
        settle();
        check_int("level saturate", int'(LEVEL), 7);
        repeat (3) step(0, 0);
        settle();
        check("min period hold", dut_vec(), vec(7, 3, 93, 198, 282, 393, 471));
        step(0, 0);
        settle();
        check("min period move", dut_vec(), vec(7, 4, 92, 200, 280, 396, 468));

        n = 0;
        while (m_x[0] != 703 && n < 5000) begin step(0, 0); n++; end
        check_int("x1 reaches 703 in bound", int'(n < 5000), 1);
        step_until_move(0);
        settle();
`ifdef CAR_LFSR_EN
        check_int("x1 lfsr wrap", int'(CAR_X1), m_x[0]);
        check_int("x1 lfsr wrap <= 63", int'(CAR_X1 <= 63), 1);
`else
        check_int("x1 right wrap", int'(CAR_X1), 0);
`endif
        n = 0;
        while (m_x[1] != 0 && n < 5000) begin step(0, 0); n++; end
        check_int("x2 reaches 0 in bound", int'(n < 5000), 1);
        step_until_move(1);
        settle();
`ifdef CAR_LFSR_EN
        check_int("x2 lfsr wrap", int'(CAR_X2), m_x[1]);
`else
        check_int("x2 left wrap", int'(CAR_X2), 703);
`endif

        async_reset("reset from level 7");
        repeat (3) step(1, 0);
        repeat (7) step(0, 0);
        settle();
        check_int("level before reset", int'(LEVEL), 3);
        async_reset("async reset at level 3");

        repeat (20000) begin
            if ($urandom_range(0, 2999) == 0) async_reset("random async reset");
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15);
        end

        settle();
        #1;
        check_int("queue drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
